// File: rtl/remote_comm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : remote_comm_pkg
//  Description : Shared types and constants for the remote_comm host-side
//                UART command transmitter / response receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
package remote_comm_pkg;

    // Packet FSM: one state per byte of the 3-byte command packet, plus idle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DHI  = 2'd2,
        ST_DLO  = 2'd3
    } pkt_state_t;

    // 50 MHz / 19200 baud.
    localparam int unsigned c_DEFAULT_BAUD_DIV = 2604;

    // Start bit + 8 data bits + stop bit.
    localparam int unsigned c_FRAME_BITS = 10;

endpackage
`default_nettype wire

// File: rtl/uart_xcvr.sv
`default_nettype none
// ============================================================================
//  Module      : uart_xcvr
//  Description : 8N1 UART transmitter and receiver sharing one baud divisor.
//                The two directions are fully independent.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_xcvr
    import remote_comm_pkg::*;
#(
    parameter int unsigned BAUD_DIV = c_DEFAULT_BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst,
    // transmitter
    input  logic       i_trmt,
    input  logic [7:0] i_tx_data,
    output logic       o_tx_done,
    output logic       o_tx,
    // receiver
    input  logic       i_rx,
    input  logic       i_clr_rdy,
    output logic       o_rdy,
    output logic [7:0] o_rx_data
);

    localparam logic [15:0] c_BIT_LAST  = 16'(BAUD_DIV - 1);
    localparam logic [15:0] c_HALF_LAST = 16'(BAUD_DIV / 2 - 1);
    localparam logic [3:0]  c_STOP_IDX  = 4'(c_FRAME_BITS - 1);

    // ---------------- transmitter ----------------
    logic        r_tx_busy;
    logic [15:0] r_tx_cnt;
    logic [3:0]  r_tx_bitn;
    logic [8:0]  r_tx_shift;   // bits still to send after the current one
    logic        r_tx;

    // Last cycle of the stop bit; a new trmt here starts the next frame back-to-back.
    assign o_tx_done = r_tx_busy && (r_tx_cnt == c_BIT_LAST) && (r_tx_bitn == c_STOP_IDX);
    assign o_tx      = r_tx;

    // Serialize start, 8 data bits LSB first, stop; trmt always restarts a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_busy  <= 1'b0;
            r_tx_cnt   <= '0;
            r_tx_bitn  <= '0;
            r_tx_shift <= '0;
            r_tx       <= 1'b1;
        end else if (i_trmt) begin
            r_tx_busy  <= 1'b1;
            r_tx_cnt   <= '0;
            r_tx_bitn  <= '0;
            r_tx_shift <= {1'b1, i_tx_data};
            r_tx       <= 1'b0;
        end else if (r_tx_busy) begin
            if (r_tx_cnt == c_BIT_LAST) begin
                r_tx_cnt <= '0;
                if (r_tx_bitn == c_STOP_IDX) begin
                    r_tx_busy <= 1'b0;
                    r_tx      <= 1'b1;
                end else begin
                    r_tx_bitn  <= r_tx_bitn + 4'd1;
                    r_tx       <= r_tx_shift[0];
                    r_tx_shift <= {1'b1, r_tx_shift[8:1]};
                end
            end else begin
                r_tx_cnt <= r_tx_cnt + 16'd1;
            end
        end
    end

    // ---------------- receiver ----------------
    logic        r_rx_s1;
    logic        r_rx_s2;
    logic        r_rx_d;
    logic        r_rx_busy;
    logic [15:0] r_rx_cnt;
    logic [3:0]  r_rx_bitn;
    logic [7:0]  r_rx_shift;
    logic [7:0]  r_rx_data;
    logic        r_rdy;
    logic        w_rx_fall;
    logic        w_rx_tick;
    logic        w_rx_done;

    assign w_rx_fall = r_rx_d & ~r_rx_s2;
    assign w_rx_tick = r_rx_busy && (r_rx_cnt == '0);
    assign w_rx_done = w_rx_tick && (r_rx_bitn == c_STOP_IDX);
    assign o_rdy     = r_rdy;
    assign o_rx_data = r_rx_data;

    // Two-flop synchronizer plus one delay flop for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_rx_d  <= 1'b1;
        end else begin
            r_rx_s1 <= i_rx;
            r_rx_s2 <= r_rx_s1;
            r_rx_d  <= r_rx_s2;
        end
    end

    // Mid-bit sampler: half a bit to the start check, then a full bit per sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_busy  <= 1'b0;
            r_rx_cnt   <= '0;
            r_rx_bitn  <= '0;
            r_rx_shift <= '0;
        end else if (!r_rx_busy) begin
            if (w_rx_fall) begin
                r_rx_busy <= 1'b1;
                r_rx_cnt  <= c_HALF_LAST;
                r_rx_bitn <= '0;
            end
        end else if (w_rx_tick) begin
            r_rx_cnt <= c_BIT_LAST;
            if ((r_rx_bitn == '0) && r_rx_s2) begin
                r_rx_busy <= 1'b0;              // glitch, not a start bit
            end else if (r_rx_bitn == c_STOP_IDX) begin
                r_rx_busy <= 1'b0;              // stop bit not checked
            end else begin
                r_rx_bitn <= r_rx_bitn + 4'd1;
                if (r_rx_bitn != '0) begin
                    r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                end
            end
        end else begin
            r_rx_cnt <= r_rx_cnt - 16'd1;
        end
    end

    // Received byte and ready flag; a completing byte beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_data <= '0;
            r_rdy     <= 1'b0;
        end else if (w_rx_done) begin
            r_rx_data <= r_rx_shift;
            r_rdy     <= 1'b1;
        end else if (i_clr_rdy) begin
            r_rdy <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/remote_comm.sv
`default_nettype none
// ============================================================================
//  Module      : remote_comm
//  Description : Sends a 3-byte command packet (cmd, data hi, data lo) over
//                UART on request and receives single-byte responses.
//  Revision    : 1.0 - initial release
// ============================================================================
module remote_comm
    import remote_comm_pkg::*;
#(
    parameter int unsigned BAUD_DIV = c_DEFAULT_BAUD_DIV
) (
    input  logic        clk,
    input  logic        rst_n,          // active-high despite the name
    input  logic [7:0]  cmd,
    input  logic [15:0] data,
    input  logic        send_cmd,
    input  logic        clr_resp_rdy,
    input  logic        RX,
    output logic        TX,
    output logic        cmd_sent,
    output logic [7:0]  resp,
    output logic        resp_rdy
);

    pkt_state_t  r_state;
    pkt_state_t  w_next;
    logic [15:0] r_data;
    logic        r_cmd_sent;
    logic        w_accept;
    logic        w_trmt;
    logic [7:0]  w_tx_byte;
    logic        w_set_sent;
    logic        w_tx_done;

    uart_xcvr #(.BAUD_DIV(BAUD_DIV)) u_xcvr (
        .clk       (clk),
        .rst       (rst_n),
        .i_trmt    (w_trmt),
        .i_tx_data (w_tx_byte),
        .o_tx_done (w_tx_done),
        .o_tx      (TX),
        .i_rx      (RX),
        .i_clr_rdy (clr_resp_rdy | w_accept),
        .o_rdy     (resp_rdy),
        .o_rx_data (resp)
    );

    assign cmd_sent = r_cmd_sent;

    // Next-state and byte mux; cmd goes straight to the UART so its start bit is not delayed.
    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_trmt     = 1'b0;
        w_tx_byte  = cmd;
        w_set_sent = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (send_cmd) begin
                    w_accept = 1'b1;
                    w_trmt   = 1'b1;
                    w_next   = ST_CMD;
                end
            end
            ST_CMD: begin
                if (w_tx_done) begin
                    w_trmt    = 1'b1;
                    w_tx_byte = r_data[15:8];
                    w_next    = ST_DHI;
                end
            end
            ST_DHI: begin
                if (w_tx_done) begin
                    w_trmt    = 1'b1;
                    w_tx_byte = r_data[7:0];
                    w_next    = ST_DLO;
                end
            end
            ST_DLO: begin
                if (w_tx_done) begin
                    w_set_sent = 1'b1;
                    w_next     = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State register, payload capture at acceptance, and the cmd_sent flag.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state    <= ST_IDLE;
            r_data     <= '0;
            r_cmd_sent <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_data     <= data;
                r_cmd_sent <= 1'b0;
            end else if (w_set_sent) begin
                r_cmd_sent <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_remote_comm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_remote_comm
//  Description : Self-checking bench for remote_comm with BAUD_DIV = 16.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_remote_comm;

    localparam int B = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        send_cmd;
    logic        clr_resp_rdy;
    logic        RX;
    logic        TX;
    logic        cmd_sent;
    logic [7:0]  resp;
    logic        resp_rdy;

    int n_tests = 0;
    int n_fail  = 0;

    remote_comm #(.BAUD_DIV(B)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd          (cmd),
        .data         (data),
        .send_cmd     (send_cmd),
        .clr_resp_rdy (clr_resp_rdy),
        .RX           (RX),
        .TX           (TX),
        .cmd_sent     (cmd_sent),
        .resp         (resp),
        .resp_rdy     (resp_rdy)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packet model: a packet is a 30-bit line stream, each bit lasting B cycles,
    // starting the cycle after acceptance; cmd_sent follows 30*B+1 cycles later.
    bit   m_valid = 1'b0;
    bit   m_busy  = 1'b0;
    bit   m_sent  = 1'b0;
    int   m_cnt   = 0;
    logic m_bits [30];

    initial begin : p_model
        logic [7:0] by;
        forever begin
            @(posedge clk);
            if (rst_n === 1'b1) begin
                m_valid = 1'b1;
                m_busy  = 1'b0;
                m_sent  = 1'b0;
                m_cnt   = 0;
            end else if (!m_busy && send_cmd === 1'b1) begin
                for (int i = 0; i < 3; i++) begin
                    by = (i == 0) ? cmd : (i == 1) ? data[15:8] : data[7:0];
                    m_bits[i*10] = 1'b0;
                    for (int j = 0; j < 8; j++) m_bits[i*10+1+j] = by[j];
                    m_bits[i*10+9] = 1'b1;
                end
                m_busy = 1'b1;
                m_sent = 1'b0;
                m_cnt  = 1;
            end else if (m_busy) begin
                m_cnt++;
                if (m_cnt > 30*B) begin
                    m_busy = 1'b0;
                    m_sent = 1'b1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison of TX and cmd_sent against the model.
    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            chk("tx_line", 32'(TX), 32'(m_busy ? m_bits[(m_cnt-1)/B] : 1'b1));
            chk("cmd_sent", 32'(cmd_sent), 32'(m_sent));
        end
    end

    // Independent UART decoder on TX collecting the bytes actually sent.
    logic [7:0] rxq[$];
    int         fe_cnt = 0;

    initial begin : p_dec
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (m_valid && TX === 1'b0) begin
                repeat (B/2) @(negedge clk);
                if (TX === 1'b0) begin
                    for (int j = 0; j < 8; j++) begin
                        repeat (B) @(negedge clk);
                        b[j] = TX;
                    end
                    repeat (B) @(negedge clk);
                    if (TX === 1'b1) rxq.push_back(b);
                    else fe_cnt++;
                end
            end
        end
    end

    task automatic start_pkt(input logic [7:0] c, input logic [15:0] d);
        @(negedge clk);
        cmd      = c;
        data     = d;
        send_cmd = 1'b1;
        @(negedge clk);
        send_cmd = 1'b0;
    endtask

    // Counts cycles from acceptance (1 = first cycle after) until cmd_sent.
    task automatic wait_sent(input int start, output int n);
        n = start;
        while (cmd_sent !== 1'b1 && n < 700) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_sent_rise", 32'(cmd_sent), 32'd1);
    endtask

    task automatic check_bytes(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        logic [7:0] exp [3];
        logic [7:0] got;
        exp[0] = b0;
        exp[1] = b1;
        exp[2] = b2;
        chk("frame_count", 32'(rxq.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            got = (i < rxq.size()) ? rxq[i] : 8'hxx;
            chk($sformatf("tx_byte%0d", i), 32'(got), 32'(exp[i]));
        end
        chk("framing_errors", 32'(fe_cnt), 32'd0);
        rxq.delete();
    endtask

    task automatic send_rx(input logic [7:0] b);
        RX = 1'b0;
        repeat (B) @(negedge clk);
        for (int j = 0; j < 8; j++) begin
            RX = b[j];
            repeat (B) @(negedge clk);
        end
        RX = 1'b1;
        repeat (B) @(negedge clk);
    endtask

    initial begin : p_main
        int n;
        rst_n        = 1'b1;
        cmd          = 8'h00;
        data         = 16'h0000;
        send_cmd     = 1'b0;
        clr_resp_rdy = 1'b0;
        RX           = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(TX), 32'd1);
        chk("rst_cmd_sent", 32'(cmd_sent), 32'd0);
        chk("rst_resp", 32'(resp), 32'h00);
        chk("rst_resp_rdy", 32'(resp_rdy), 32'd0);
        rst_n = 1'b0;
        repeat (5) @(negedge clk);

        // Set thrust packet: exact cmd_sent latency.
        start_pkt(8'h05, 16'h00FF);
        wait_sent(1, n);
        chk("cmd_sent_latency", 32'(n), 32'd481);
        repeat (20) @(negedge clk);
        check_bytes(8'h05, 8'h00, 8'hFF);

        // Payload captured at acceptance; mid-packet request ignored.
        @(negedge clk);
        cmd      = 8'h02;
        data     = 16'h0100;
        send_cmd = 1'b1;
        @(negedge clk);
        send_cmd = 1'b0;
        data     = 16'hFFFF;
        cmd      = 8'hEE;
        repeat (100) @(negedge clk);
        send_cmd = 1'b1;
        @(negedge clk);
        send_cmd = 1'b0;
        wait_sent(102, n);
        repeat (12*B) @(negedge clk);
        check_bytes(8'h02, 8'h01, 8'h00);

        // Response reception concurrent with a transmit.
        start_pkt(8'h10, 16'h1234);
        chk("rdy_before_rx", 32'(resp_rdy), 32'd0);
        send_rx(8'hA5);
        @(negedge clk);
        chk("resp_a5", 32'(resp), 32'hA5);
        chk("resp_rdy_a5", 32'(resp_rdy), 32'd1);
        wait_sent(B*10 + 2, n);
        repeat (20) @(negedge clk);
        check_bytes(8'h10, 8'h12, 8'h34);

        // clr_resp_rdy, then a new send_cmd also clears.
        clr_resp_rdy = 1'b1;
        @(negedge clk);
        clr_resp_rdy = 1'b0;
        chk("clr_rdy", 32'(resp_rdy), 32'd0);
        chk("clr_resp_hold", 32'(resp), 32'hA5);
        send_rx(8'h3C);
        repeat (4) @(negedge clk);
        chk("resp_3c", 32'(resp), 32'h3C);
        chk("resp_rdy_3c", 32'(resp_rdy), 32'd1);
        start_pkt(8'h20, 16'h0000);
        chk("send_clears_rdy", 32'(resp_rdy), 32'd0);
        chk("send_resp_hold", 32'(resp), 32'h3C);
        wait_sent(1, n);
        repeat (20) @(negedge clk);
        check_bytes(8'h20, 8'h00, 8'h00);

        // Reset during the DHI byte.
        start_pkt(8'h07, 16'hABCD);
        send_rx(8'h5A);
        repeat (4) @(negedge clk);
        chk("resp_5a", 32'(resp), 32'h5A);
        chk("resp_rdy_5a", 32'(resp_rdy), 32'd1);
        repeat (40) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        chk("midrst_tx", 32'(TX), 32'd1);
        chk("midrst_cmd_sent", 32'(cmd_sent), 32'd0);
        chk("midrst_resp_rdy", 32'(resp_rdy), 32'd0);
        chk("midrst_resp", 32'(resp), 32'h00);
        repeat (12*B) @(negedge clk);
        rxq.delete();
        fe_cnt = 0;
        start_pkt(8'h08, 16'h00C3);
        wait_sent(1, n);
        chk("post_rst_latency", 32'(n), 32'd481);
        repeat (20) @(negedge clk);
        check_bytes(8'h08, 8'h00, 8'hC3);

        // False start: short low glitch produces nothing.
        RX = 1'b0;
        repeat (4) @(negedge clk);
        RX = 1'b1;
        repeat (20*B) @(negedge clk);
        chk("glitch_rdy", 32'(resp_rdy), 32'd0);
        chk("glitch_resp", 32'(resp), 32'h00);
        send_rx(8'h96);
        repeat (4) @(negedge clk);
        chk("resp_96", 32'(resp), 32'h96);
        chk("resp_rdy_96", 32'(resp_rdy), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : p_watchdog
        #5_000_000;
        $display("FAIL watchdog: run exceeded time limit, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
